// File: rtl/mem_xbar_pkg.sv
// -----------------------------------------------------------------------------
// mem_xbar_pkg
// Shared constants, types and helpers for the mem_xbar_rr bank-to-client
// crossbar and its round-robin arbiter.
//   N_SRC_DEF / N_DST_DEF / DATA_W_DEF : default crossbar geometry
//   data_t                             : default-width data word
//   idx_w(n)                           : index width for n items, never below 1
// -----------------------------------------------------------------------------
package mem_xbar_pkg;

    localparam int N_SRC_DEF  = 16;
    localparam int N_DST_DEF  = 32;
    localparam int DATA_W_DEF = 256;

    typedef logic [DATA_W_DEF-1:0] data_t;

    // A single item still needs a 1-bit index so port widths never collapse to 0.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mem_xbar_rr_arb.sv
// -----------------------------------------------------------------------------
// rr_arb
// N-way round-robin arbiter with its own rotating priority pointer.
// The grant goes to the lowest requesting index at or above the pointer,
// otherwise to the lowest requesting index overall. The pointer advances to
// one past the winner whenever a grant is issued (en && |req).
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset (pointer -> 0)
//   req  [N]   : request vector
//   en         : grant permission (the destination can take a word)
//   gnt  [N]   : one-hot grant, all zero when !en or no request
//   gnt_idx[W] : index of the winning requester (valid whenever |req)
// -----------------------------------------------------------------------------
module rr_arb
    import mem_xbar_pkg::*;
#(
    parameter  int N = 16,
    localparam int W = idx_w(N)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] req,
    input  logic         en,
    output logic [N-1:0] gnt,
    output logic [W-1:0] gnt_idx
);

    logic [W-1:0] ptr;
    logic [W-1:0] idx_hi;
    logic [W-1:0] idx_lo;
    logic         found_hi;

    always_comb begin
        // NOTE: every combinationally assigned signal gets a default before any
        // conditional so no path leaves it unassigned (which would infer a latch).
        idx_hi   = '0;
        idx_lo   = '0;
        found_hi = 1'b0;
        gnt      = '0;
        // Scanning downwards leaves the lowest matching index in each slot.
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                idx_lo = W'(i);
                if (i >= int'(ptr)) begin
                    idx_hi   = W'(i);
                    found_hi = 1'b1;
                end
            end
        end
        gnt_idx = found_hi ? idx_hi : idx_lo;
        if (en && (|req)) begin
            gnt[gnt_idx] = 1'b1;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the values present before the edge, independent of block ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (en && (|req)) begin
            ptr <= (int'(gnt_idx) == N - 1) ? '0 : gnt_idx + W'(1);
        end
    end

endmodule

// File: rtl/mem_xbar_rr.sv
// -----------------------------------------------------------------------------
// mem_xbar_rr
// Registered crossbar from N_SRC memory banks to N_DST clients. Each source
// offers a word plus a destination index; each destination runs its own
// round-robin arbiter and owns a one-entry output register that tolerates
// client backpressure. A pop and a new grant in the same cycle keep the
// register full (no bubble). Words addressed to a non-existent destination
// are accepted at once and discarded.
// Optional build macro: MEM_XBAR_DROP_CNT_EN adds a saturating 16-bit count
// of discarded words on drop_cnt.
// Ports:
//   clk, rst_n                 : clock, asynchronous active-low reset
//   src_valid/src_data/src_dst : source word offers (held until src_ready)
//   src_ready                  : combinational accept, low while in reset
//   dst_valid/dst_data/dst_src : output registers and source of held word
//   dst_ready                  : client consumes the held word
//   drop_cnt                   : (MEM_XBAR_DROP_CNT_EN only) discarded words
// -----------------------------------------------------------------------------
module mem_xbar_rr
    import mem_xbar_pkg::*;
#(
    parameter  int N_SRC  = N_SRC_DEF,
    parameter  int N_DST  = N_DST_DEF,
    parameter  int DATA_W = DATA_W_DEF,
    localparam int DST_W  = idx_w(N_DST),
    localparam int SRC_W  = idx_w(N_SRC)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [N_SRC-1:0]              src_valid,
    input  logic [N_SRC-1:0][DATA_W-1:0]  src_data,
    input  logic [N_SRC-1:0][DST_W-1:0]   src_dst,
    output logic [N_SRC-1:0]              src_ready,
    output logic [N_DST-1:0]              dst_valid,
    output logic [N_DST-1:0][DATA_W-1:0]  dst_data,
    output logic [N_DST-1:0][SRC_W-1:0]   dst_src,
    input  logic [N_DST-1:0]              dst_ready
`ifdef MEM_XBAR_DROP_CNT_EN
    ,
    output logic [15:0]                   drop_cnt
`endif
);

    logic [N_SRC-1:0] req [N_DST];
    logic [N_SRC-1:0] gnt [N_DST];
    logic [SRC_W-1:0] gnt_idx [N_DST];
    logic [N_DST-1:0] dst_open;
    logic [N_SRC-1:0] gnt_any;
    logic [N_SRC-1:0] drop;

    // Per-destination request vectors; out-of-range indices match nobody.
    always_comb begin
        for (int d = 0; d < N_DST; d++) begin
            for (int s = 0; s < N_SRC; s++) begin
                req[d][s] = src_valid[s] && (int'(src_dst[s]) == d);
            end
        end
    end

    // A word for a destination that does not exist is taken and discarded.
    always_comb begin
        for (int s = 0; s < N_SRC; s++) begin
            drop[s] = src_valid[s] && (int'(src_dst[s]) >= N_DST);
        end
    end

    // src_dst is single-valued, so at most one destination grants any source.
    always_comb begin
        gnt_any = '0;
        for (int d = 0; d < N_DST; d++) begin
            gnt_any = gnt_any | gnt[d];
        end
    end

    assign src_ready = (gnt_any | drop) & {N_SRC{rst_n}};

    for (genvar d = 0; d < N_DST; d++) begin : g_dst
        logic              v_q;
        logic [DATA_W-1:0] data_q;
        logic [SRC_W-1:0]  src_q;

        assign dst_open[d]  = !v_q || dst_ready[d];
        assign dst_valid[d] = v_q;
        assign dst_data[d]  = data_q;
        assign dst_src[d]   = src_q;

        rr_arb #(.N(N_SRC)) u_arb (
            .clk     (clk),
            .rst_n   (rst_n),
            .req     (req[d]),
            .en      (dst_open[d]),
            .gnt     (gnt[d]),
            .gnt_idx (gnt_idx[d])
        );

        // NOTE: the data register is reset even though it is wide, because its
        // post-reset value (zero) is observable on dst_data. It is not cleared
        // on a pop: it keeps the last word while dst_valid is low.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                v_q    <= 1'b0;
                data_q <= '0;
                src_q  <= '0;
            end else if (dst_open[d]) begin
                if (|req[d]) begin
                    v_q    <= 1'b1;
                    data_q <= src_data[gnt_idx[d]];
                    src_q  <= gnt_idx[d];
                end else begin
                    v_q    <= 1'b0;
                end
            end
        end
    end

`ifdef MEM_XBAR_DROP_CNT_EN
    logic [31:0] drop_sum;

    assign drop_sum = 32'(drop_cnt) + 32'($countones(drop));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_cnt <= '0;
        end else begin
            drop_cnt <= (drop_sum > 32'h0000_FFFF) ? 16'hFFFF : drop_sum[15:0];
        end
    end
`endif

endmodule

// File: tb/tb_mem_xbar_rr.sv
// -----------------------------------------------------------------------------
// tb_mem_xbar_rr
// Self-checking bench for mem_xbar_rr. The main instance (16 x 32 x 256) is
// compared every cycle against a queue-free behavioural model that scans each
// destination's sources cyclically from its priority pointer. A second
// instance with 20 destinations exercises out-of-range dropping (and drop_cnt
// when MEM_XBAR_DROP_CNT_EN is defined).
// -----------------------------------------------------------------------------
module tb_mem_xbar_rr;
    import mem_xbar_pkg::*;

    localparam int N_SRC  = N_SRC_DEF;
    localparam int N_DST  = N_DST_DEF;
    localparam int DATA_W = DATA_W_DEF;
    localparam int DST_W  = idx_w(N_DST);
    localparam int SRC_W  = idx_w(N_SRC);
    localparam int N_DST2 = 20;
    localparam int DW2    = 16;
    localparam int DST_W2 = idx_w(N_DST2);
    localparam int W      = DATA_W;

    logic clk;
    logic rst_n;

    logic [N_SRC-1:0]             src_valid;
    logic [N_SRC-1:0][DATA_W-1:0] src_data;
    logic [N_SRC-1:0][DST_W-1:0]  src_dst;
    logic [N_SRC-1:0]             src_ready;
    logic [N_DST-1:0]             dst_valid;
    logic [N_DST-1:0][DATA_W-1:0] dst_data;
    logic [N_DST-1:0][SRC_W-1:0]  dst_src;
    logic [N_DST-1:0]             dst_ready;

    logic [N_SRC-1:0]             src_valid2;
    logic [N_SRC-1:0][DW2-1:0]    src_data2;
    logic [N_SRC-1:0][DST_W2-1:0] src_dst2;
    logic [N_SRC-1:0]             src_ready2;
    logic [N_DST2-1:0]            dst_valid2;
    logic [N_DST2-1:0][DW2-1:0]   dst_data2;
    logic [N_DST2-1:0][SRC_W-1:0] dst_src2;
    logic [N_DST2-1:0]            dst_ready2;
`ifdef MEM_XBAR_DROP_CNT_EN
    logic [15:0] drop_cnt;
    logic [15:0] drop_cnt2;
`endif

    mem_xbar_rr #(.N_SRC(N_SRC), .N_DST(N_DST), .DATA_W(DATA_W)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .src_valid (src_valid),
        .src_data  (src_data),
        .src_dst   (src_dst),
        .src_ready (src_ready),
        .dst_valid (dst_valid),
        .dst_data  (dst_data),
        .dst_src   (dst_src),
        .dst_ready (dst_ready)
`ifdef MEM_XBAR_DROP_CNT_EN
        ,
        .drop_cnt  (drop_cnt)
`endif
    );

    mem_xbar_rr #(.N_SRC(N_SRC), .N_DST(N_DST2), .DATA_W(DW2)) u_dut2 (
        .clk       (clk),
        .rst_n     (rst_n),
        .src_valid (src_valid2),
        .src_data  (src_data2),
        .src_dst   (src_dst2),
        .src_ready (src_ready2),
        .dst_valid (dst_valid2),
        .dst_data  (dst_data2),
        .dst_src   (dst_src2),
        .dst_ready (dst_ready2)
`ifdef MEM_XBAR_DROP_CNT_EN
        ,
        .drop_cnt  (drop_cnt2)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit    m_valid [N_DST];
    data_t m_data  [N_DST];
    int    m_src   [N_DST];
    int    m_ptr   [N_DST];
    bit    n_valid [N_DST];
    data_t n_data  [N_DST];
    int    n_src   [N_DST];
    int    n_ptr   [N_DST];
    logic [N_SRC-1:0] exp_ready;
    logic [N_SRC-1:0] last_ready;

    task automatic model_reset();
        for (int d = 0; d < N_DST; d++) begin
            m_valid[d] = 1'b0;
            m_data[d]  = '0;
            m_src[d]   = 0;
            m_ptr[d]   = 0;
        end
    endtask

    // Computes this cycle's accepts and the state after the coming edge.
    task automatic model_eval();
        int g;
        exp_ready = '0;
        for (int d = 0; d < N_DST; d++) begin
            n_valid[d] = m_valid[d];
            n_data[d]  = m_data[d];
            n_src[d]   = m_src[d];
            n_ptr[d]   = m_ptr[d];
        end
        if (rst_n) begin
            for (int s = 0; s < N_SRC; s++) begin
                if (src_valid[s] && int'(src_dst[s]) >= N_DST) exp_ready[s] = 1'b1;
            end
            for (int d = 0; d < N_DST; d++) begin
                if (!m_valid[d] || dst_ready[d]) begin
                    g = -1;
                    for (int k = 0; k < N_SRC; k++) begin
                        int s;
                        s = (m_ptr[d] + k) % N_SRC;
                        if (g < 0 && src_valid[s] && int'(src_dst[s]) == d) g = s;
                    end
                    if (g >= 0) begin
                        exp_ready[g] = 1'b1;
                        n_valid[d]   = 1'b1;
                        n_data[d]    = src_data[g];
                        n_src[d]     = g;
                        n_ptr[d]     = (g + 1) % N_SRC;
                    end else begin
                        n_valid[d] = 1'b0;
                    end
                end
            end
        end
    endtask

    // One clock: inputs already driven at the falling edge.
    task automatic cycle();
        logic [N_DST-1:0] exp_v;
        #1;
        model_eval();
        last_ready = src_ready;
        check("src_ready", W'(src_ready), W'(exp_ready));
        @(posedge clk);
        #1;
        for (int d = 0; d < N_DST; d++) begin
            m_valid[d] = n_valid[d];
            m_data[d]  = n_data[d];
            m_src[d]   = n_src[d];
            m_ptr[d]   = n_ptr[d];
            exp_v[d]   = n_valid[d];
        end
        check("dst_valid", W'(dst_valid), W'(exp_v));
        for (int d = 0; d < N_DST; d++) begin
            check($sformatf("dst_data[%0d]", d), W'(dst_data[d]), W'(m_data[d]));
            check($sformatf("dst_src[%0d]", d), W'(dst_src[d]), W'(m_src[d]));
        end
        @(negedge clk);
    endtask

    function automatic data_t rand_word();
        data_t w;
        for (int i = 0; i < DATA_W / 32; i++) w[i*32 +: 32] = $urandom;
        return w;
    endfunction

    function automatic logic [N_SRC-1:0] onehot(input int i);
        logic [N_SRC-1:0] v;
        v    = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    // ---------------- stimulus ----------------
    initial begin
        data_t d1;
        data_t d2;
        rst_n      = 1'b0;
        src_valid  = '0;
        src_data   = '0;
        src_dst    = '0;
        dst_ready  = '0;
        src_valid2 = '0;
        src_data2  = '0;
        src_dst2   = '0;
        dst_ready2 = '0;
        last_ready = '0;
        model_reset();

        // Reset: a pending request must not be accepted while reset is held.
        src_valid[3] = 1'b1;
        #1;
        check("rst_src_ready", W'(src_ready), W'(0));
        check("rst_dst_valid", W'(dst_valid), W'(0));
        check("rst_dst_data0", W'(dst_data[0]), W'(0));
        @(negedge clk);
        rst_n     = 1'b1;
        src_valid = '0;

        // Single path: src 3 -> dst 7.
        dst_ready    = '1;
        src_valid[3] = 1'b1;
        src_dst[3]   = DST_W'(7);
        src_data[3]  = {32{8'hA5}};
        cycle();
        check("single_ready", W'(last_ready), W'(16'h0008));
        src_valid[3] = 1'b0;
        check("single_valid", W'(dst_valid), W'(32'h0000_0080));
        check("single_data", W'(dst_data[7]), {32{8'hA5}});
        check("single_src", W'(dst_src[7]), W'(3));

        // Collision on dst 0: 2, 5, 9, then 12 beats 1 (pointer at 10).
        foreach (src_dst[s]) src_dst[s] = '0;
        src_valid[2] = 1'b1; src_data[2] = rand_word();
        src_valid[5] = 1'b1; src_data[5] = rand_word();
        src_valid[9] = 1'b1; src_data[9] = rand_word();
        cycle(); check("coll_g2", W'(last_ready), W'(onehot(2))); src_valid[2] = 1'b0;
        cycle(); check("coll_g5", W'(last_ready), W'(onehot(5))); src_valid[5] = 1'b0;
        cycle(); check("coll_g9", W'(last_ready), W'(onehot(9))); src_valid[9] = 1'b0;
        src_valid[1]  = 1'b1; src_data[1]  = rand_word();
        src_valid[12] = 1'b1; src_data[12] = rand_word();
        cycle(); check("coll_g12", W'(last_ready), W'(onehot(12))); src_valid[12] = 1'b0;
        check("coll_src12", W'(dst_src[0]), W'(12));
        cycle(); check("coll_g1", W'(last_ready), W'(onehot(1))); src_valid[1] = 1'b0;

        // Backpressure on dst 4.
        d1 = rand_word();
        d2 = rand_word();
        dst_ready[4] = 1'b0;
        src_valid[0] = 1'b1;
        src_dst[0]   = DST_W'(4);
        src_data[0]  = d1;
        cycle(); check("bp_first", W'(last_ready[0]), W'(1));
        src_data[0] = d2;
        for (int i = 0; i < 5; i++) begin
            cycle(); check("bp_stall", W'(last_ready[0]), W'(0));
        end
        check("bp_hold", W'(dst_data[4]), d1);
        dst_ready[4] = 1'b1;
        cycle(); check("bp_regrant", W'(last_ready[0]), W'(1));
        check("bp_nobubble", W'(dst_valid[4]), W'(1));
        check("bp_data", W'(dst_data[4]), d2);
        src_valid[0] = 1'b0;

        // Parallel: src s -> dst 16+s.
        cycle();
        check("par_idle", W'(dst_valid), W'(0));
        for (int s = 0; s < N_SRC; s++) begin
            src_valid[s] = 1'b1;
            src_dst[s]   = DST_W'(16 + s);
            src_data[s]  = rand_word();
        end
        cycle();
        check("par_ready", W'(last_ready), W'(16'hFFFF));
        check("par_valid", W'(dst_valid), W'(32'hFFFF_0000));
        for (int s = 0; s < N_SRC; s++) check("par_src", W'(dst_src[16+s]), W'(s));
        src_valid = '0;

        // Out-of-range on the 20-destination instance: src 6 -> 25, src 1 -> 19.
        dst_ready2    = '1;
        src_valid2[6] = 1'b1; src_dst2[6] = DST_W2'(25);
        src_valid2[1] = 1'b1; src_dst2[1] = DST_W2'(19); src_data2[1] = 16'hBEEF;
        #1;
        check("oor_ready", W'(src_ready2), W'(16'h0042));
`ifdef MEM_XBAR_DROP_CNT_EN
        check("oor_cnt0", W'(drop_cnt2), W'(0));
`endif
        cycle();
        check("oor_valid", W'(dst_valid2), W'(20'h8_0000));
        check("oor_src", W'(dst_src2[19]), W'(1));
        check("oor_data", W'(dst_data2[19]), W'(16'hBEEF));
`ifdef MEM_XBAR_DROP_CNT_EN
        check("oor_cnt1", W'(drop_cnt2), W'(1));
`endif
        src_valid2 = '0;
`ifdef MEM_XBAR_DROP_CNT_EN
        for (int s = 0; s < N_SRC; s++) begin
            src_valid2[s] = 1'b1;
            src_dst2[s]   = DST_W2'(31);
        end
        repeat (4400) @(negedge clk);
        check("drop_sat", W'(drop_cnt2), W'(16'hFFFF));
        check("drop_main", W'(drop_cnt), W'(0));
        src_valid2 = '0;
`endif

        // Randomised traffic against the model.
        exp_ready = '0;
        for (int c = 0; c < 2000; c++) begin
            for (int s = 0; s < N_SRC; s++) begin
                if (!src_valid[s] || exp_ready[s]) begin
                    src_valid[s] = ($urandom_range(0, 9) < 6);
                    src_dst[s]   = (c < 1000) ? DST_W'($urandom_range(0, 3))
                                              : DST_W'($urandom_range(0, N_DST - 1));
                    src_data[s]  = rand_word();
                end else if ($urandom_range(0, 19) == 0) begin
                    src_valid[s] = 1'b0;
                end
            end
            for (int d = 0; d < N_DST; d++) dst_ready[d] = ($urandom_range(0, 9) < 7);
            cycle();
        end

        // Reset mid-burst: pointer of dst 0 is moved off zero first.
        src_valid = '0;
        dst_ready = '1;
        cycle();
        foreach (src_dst[s]) src_dst[s] = '0;
        src_valid[2] = 1'b1;
        src_valid[5] = 1'b1;
        src_valid[9] = 1'b1;
        dst_ready[0] = 1'b0;
        cycle();
        check("mid_valid_pre", W'(dst_valid[0]), W'(1));
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", W'(dst_valid), W'(0));
        check("mid_rst_ready", W'(src_ready), W'(0));
        model_reset();
        @(negedge clk);
        rst_n        = 1'b1;
        dst_ready[0] = 1'b1;
        cycle();
        check("mid_regrant", W'(last_ready), W'(onehot(2)));
        src_valid = '0;
        cycle();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
